// File: rtl/load_mem_data.sv
// Load-data alignment unit: extracts and extends the addressed byte or halfword
// of an aligned memory word and flags misaligned loads, with one cycle of latency.
module load_mem_data (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MemOutput_pre,
  input  logic [31:0] ALUresult_M,
  input  logic [3:0]  Loadop,
  output logic [31:0] MemOutput,
  output logic        AdEL
);

  typedef enum logic [3:0] {
    OP_LW  = 4'd0,
    OP_LBU = 4'd1,
    OP_LB  = 4'd2,
    OP_LHU = 4'd3,
    OP_LH  = 4'd4
  } load_op_e;

  logic [1:0]  byte_addr;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] next_data;
  logic        next_adel;
  logic        unused_addr_bits;

  // Only the low two address bits matter; the word address was already used by the memory.
  assign byte_addr        = ALUresult_M[1:0];
  assign unused_addr_bits = ^ALUresult_M[31:2];

  always_comb begin
    sel_byte = MemOutput_pre[7:0];
    case (byte_addr)
      2'd0:    sel_byte = MemOutput_pre[7:0];
      2'd1:    sel_byte = MemOutput_pre[15:8];
      2'd2:    sel_byte = MemOutput_pre[23:16];
      default: sel_byte = MemOutput_pre[31:24];
    endcase
  end

  assign sel_half = byte_addr[1] ? MemOutput_pre[31:16] : MemOutput_pre[15:0];

  // Data is extracted even when misaligned; AdEL is reported alongside, not instead.
  always_comb begin
    next_data = MemOutput_pre;
    next_adel = 1'b0;
    case (Loadop)
      OP_LW: begin
        next_data = MemOutput_pre;
        next_adel = (byte_addr != 2'd0);
      end
      OP_LBU: next_data = {24'b0, sel_byte};
      OP_LB:  next_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LHU: begin
        next_data = {16'b0, sel_half};
        next_adel = byte_addr[0];
      end
      OP_LH: begin
        next_data = {{16{sel_half[15]}}, sel_half};
        next_adel = byte_addr[0];
      end
      default: begin
        next_data = MemOutput_pre;
        next_adel = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      MemOutput <= 32'h0000_0000;
      AdEL      <= 1'b0;
    end else begin
      MemOutput <= next_data;
      AdEL      <= next_adel;
    end
  end

endmodule

// File: tb/tb_load_mem_data.sv
// Self-checking bench for load_mem_data: directed literal vectors plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_load_mem_data;

  logic        clk;
  logic        reset;
  logic [31:0] MemOutput_pre;
  logic [31:0] ALUresult_M;
  logic [3:0]  Loadop;
  logic [31:0] MemOutput;
  logic        AdEL;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_mem;
  logic        exp_adel;
  bit          model_ready = 0;

  load_mem_data dut (
    .clk(clk),
    .reset(reset),
    .MemOutput_pre(MemOutput_pre),
    .ALUresult_M(ALUresult_M),
    .Loadop(Loadop),
    .MemOutput(MemOutput),
    .AdEL(AdEL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {adel, data} from plain shifts, masks and additions.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] pre);
    int unsigned k;
    logic [31:0] b, h, data;
    logic        ad;
    k    = a % 4;
    b    = (pre >> (8 * k)) & 32'hFF;
    h    = (pre >> (16 * (k / 2))) & 32'hFFFF;
    data = pre;
    ad   = 1'b0;
    case (op)
      4'd0: ad = (k != 0);
      4'd1: data = b;
      4'd2: data = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4'd3: begin data = h; ad = (k % 2 == 1); end
      4'd4: begin data = (h >= 32768) ? h + 32'hFFFF_0000 : h; ad = (k % 2 == 1); end
      default: begin data = pre; ad = 1'b0; end
    endcase
    return {ad, data};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  task automatic applyStimulus(input logic rst, input logic [31:0] pre, input logic [31:0] addr,
                               input logic [3:0] op);
    reset         = rst;
    MemOutput_pre = pre;
    ALUresult_M   = addr;
    Loadop        = op;
  endtask

  // Drive one load, let it cross one edge, and compare with hand-computed values.
  task automatic directed(input string name, input logic [31:0] pre, input logic [31:0] addr,
                          input logic [3:0] op, input logic [31:0] mem, input logic adel);
    applyStimulus(1'b0, pre, addr, op);
    @(posedge clk);
    #1;
    checkOutput({name, "_data"}, MemOutput, mem);
    checkOutput({name, "_adel"}, {31'b0, AdEL}, {31'b0, adel});
  endtask

  always @(posedge clk) begin
    logic [32:0] r;
    if (reset) begin
      exp_mem     = 32'h0;
      exp_adel    = 1'b0;
      model_ready = 1;
    end else begin
      r        = model(Loadop, ALUresult_M, MemOutput_pre);
      exp_mem  = r[31:0];
      exp_adel = r[32];
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("cycle_data", MemOutput, exp_mem);
      checkOutput("cycle_adel", {31'b0, AdEL}, {31'b0, exp_adel});
    end
  end

  initial begin
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_data", MemOutput, 32'h0000_0000);
    checkOutput("reset_adel", {31'b0, AdEL}, 32'h0);

    directed("lbu_a1",   32'h8899_AABB, 32'h1, 4'd1, 32'h0000_00AA, 1'b0);
    directed("lb_a1",    32'h8899_AABB, 32'h1, 4'd2, 32'hFFFF_FFAA, 1'b0);
    directed("lb_a0",    32'h1122_3377, 32'h0, 4'd2, 32'h0000_0077, 1'b0);
    directed("lh_a2",    32'h8899_AABB, 32'h2, 4'd4, 32'hFFFF_8899, 1'b0);
    directed("lhu_a2",   32'h8899_AABB, 32'h2, 4'd3, 32'h0000_8899, 1'b0);
    directed("lhu_a0",   32'h8899_AABB, 32'h0, 4'd3, 32'h0000_AABB, 1'b0);
    directed("lw_a3",    32'h8899_AABB, 32'h3, 4'd0, 32'h8899_AABB, 1'b1);
    directed("lh_a1",    32'h8899_AABB, 32'h1, 4'd4, 32'hFFFF_AABB, 1'b1);
    directed("lb_a3",    32'h8899_AABB, 32'h3, 4'd2, 32'hFFFF_FF88, 1'b0);
    directed("rsvd_a2",  32'h1234_5678, 32'h2, 4'd9, 32'h1234_5678, 1'b0);
    directed("lbu_hiad", 32'hDEAD_BEEF, 32'hFFFF_FFF6, 4'd1, 32'h0000_00AD, 1'b0);

    // A pending load is discarded when reset lands on its edge.
    applyStimulus(1'b1, 32'h8899_AABB, 32'h3, 4'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst_data", MemOutput, 32'h0);
    checkOutput("midrst_adel", {31'b0, AdEL}, 32'h0);
    directed("after_rst", 32'hCAFE_F00D, 32'h2, 4'd3, 32'h0000_CAFE, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      applyStimulus(($urandom_range(0, 24) == 0), $urandom, $urandom, op);
      @(posedge clk);
      #1;
    end

    applyStimulus(1'b0, 32'h0, 32'h0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
